// File: rtl/dma_arbiter.sv
// dma_arbiter
//   Shares one DMA engine among NREQ command sources. Each source fires a
//   one-cycle start with an opcode and four 32-bit fields; the command is
//   held in that source's slot until the DMA reports completion. Slots are
//   served round-robin, and the owner receives a one-cycle done pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_start[NREQ]          command strobe per requester
//   req_op[3*NREQ]           opcode, requester i at [3i+2:3i]
//   req_info1/_mem_info1/
//   req_info2/_mem_info2     32-bit fields, requester i at [32i+31:32i]
//   req_done[NREQ]           completion pulse to the owning requester
//   req_err[NREQ]            pulse: strobe dropped, slot already pending
//   dma_start                one-cycle start to the DMA engine
//   dma_op, dma_info*        fields of the granted command, stable until next grant
//   f_dma                    DMA finished pulse
//   busy                     high while a command is issued or in flight
//   grant_id                 index of the current or last granted requester
module dma_arbiter #(
  parameter int NREQ = 3,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_start,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_info1,
  input  logic [32*NREQ-1:0]   req_mem_info1,
  input  logic [32*NREQ-1:0]   req_info2,
  input  logic [32*NREQ-1:0]   req_mem_info2,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic                 dma_start,
  output logic [2:0]           dma_op,
  output logic [31:0]          dma_info1,
  output logic [31:0]          dma_mem_info1,
  output logic [31:0]          dma_info2,
  output logic [31:0]          dma_mem_info2,
  input  logic                 f_dma,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]      state;
  logic [NREQ-1:0] pending;
  logic [GW-1:0]   last_grant;

  logic [2:0]  slot_op        [NREQ];
  logic [31:0] slot_info1     [NREQ];
  logic [31:0] slot_mem_info1 [NREQ];
  logic [31:0] slot_info2     [NREQ];
  logic [31:0] slot_mem_info2 [NREQ];

  logic [NREQ-1:0] clear_vec;  // slot completing this cycle
  logic [NREQ-1:0] accept;     // strobe captured this cycle
  logic            sel_valid;
  logic [GW-1:0]   sel_idx;
  logic [GW-1:0]   cand;

  // A strobe is accepted into an empty slot, or into the slot that is being
  // released this very cycle (set wins over clear).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    clear_vec = '0;
    accept    = '0;
    for (int i = 0; i < NREQ; i++) begin
      clear_vec[i] = (state == S_WAIT) && f_dma && (grant_id == GW'(i));
      accept[i]    = req_start[i] && (!pending[i] || clear_vec[i]);
    end
  end

  // Round-robin pick: scan last_grant+1, +2, ... and keep the closest pending
  // index. Walking the offsets from far to near lets the nearest win.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NREQ);
      if (pending[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // NOTE: slot payload has no reset; pending[] alone says whether it is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        slot_op[i]        <= req_op[3*i +: 3];
        slot_info1[i]     <= req_info1[32*i +: 32];
        slot_mem_info1[i] <= req_mem_info1[32*i +: 32];
        slot_info2[i]     <= req_info2[32*i +: 32];
        slot_mem_info2[i] <= req_mem_info2[32*i +: 32];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pending       <= '0;
      last_grant    <= GW'(NREQ - 1);
      grant_id      <= '0;
      dma_start     <= 1'b0;
      dma_op        <= '0;
      dma_info1     <= '0;
      dma_mem_info1 <= '0;
      dma_info2     <= '0;
      dma_mem_info2 <= '0;
      req_done      <= '0;
      req_err       <= '0;
      busy          <= 1'b0;
    end else begin
      dma_start <= 1'b0;
      req_done  <= '0;
      req_err   <= req_start & pending & ~clear_vec;

      for (int i = 0; i < NREQ; i++) begin
        if (accept[i])         pending[i] <= 1'b1;
        else if (clear_vec[i]) pending[i] <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            grant_id      <= sel_idx;
            dma_op        <= slot_op[sel_idx];
            dma_info1     <= slot_info1[sel_idx];
            dma_mem_info1 <= slot_mem_info1[sel_idx];
            dma_info2     <= slot_info2[sel_idx];
            dma_mem_info2 <= slot_mem_info2[sel_idx];
            dma_start     <= 1'b1;
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (f_dma) begin
            req_done[grant_id] <= 1'b1;
            last_grant         <= grant_id;
            busy               <= 1'b0;
            state              <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter
//   Directed stimulus for dma_arbiter with a scoreboard: the stimulus side
//   pushes the commands it expects the DMA to see, the owners it expects to
//   be told "done", and the requesters it expects to be rejected. A monitor
//   pops and compares whenever the DUT shows dma_start, req_done or req_err.
//   A small DMA model answers each start with f_dma after dma_lat cycles.
module tb_dma_arbiter;

  localparam int NREQ = 3;
  localparam int GW   = 2;

  typedef struct packed {
    logic [GW-1:0] id;
    logic [2:0]    op;
    logic [31:0]   i1;
    logic [31:0]   m1;
    logic [31:0]   i2;
    logic [31:0]   m2;
  } cmd_t;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_start;
  logic [3*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_info1, req_mem_info1, req_info2, req_mem_info2;
  logic [NREQ-1:0]      req_done, req_err;
  logic                 dma_start;
  logic [2:0]           dma_op;
  logic [31:0]          dma_info1, dma_mem_info1, dma_info2, dma_mem_info2;
  logic                 f_dma;
  logic                 busy;
  logic [GW-1:0]        grant_id;

  dma_arbiter #(.NREQ(NREQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_start     (req_start),
    .req_op        (req_op),
    .req_info1     (req_info1),
    .req_mem_info1 (req_mem_info1),
    .req_info2     (req_info2),
    .req_mem_info2 (req_mem_info2),
    .req_done      (req_done),
    .req_err       (req_err),
    .dma_start     (dma_start),
    .dma_op        (dma_op),
    .dma_info1     (dma_info1),
    .dma_mem_info1 (dma_mem_info1),
    .dma_info2     (dma_info2),
    .dma_mem_info2 (dma_mem_info2),
    .f_dma         (f_dma),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_t exp_issue[$];
  int   exp_done[$];
  int   exp_err[$];

  int   dma_lat   = 5;
  logic force_fin = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int id, input int op, input int n);
    cmd_t c;
    c.id = GW'(id);
    c.op = 3'(op);
    c.i1 = 32'h1000_0000 + 32'(n);
    c.m1 = 32'h2000_0000 + 32'(n);
    c.i2 = 32'h3000_0000 + 32'(n);
    c.m2 = 32'h4000_0000 + 32'(n);
    return c;
  endfunction

  // Place a command on its requester's lanes and raise its strobe.
  task automatic drive(input cmd_t c);
    int i;
    i = int'(c.id);
    req_start[i]           = 1'b1;
    req_op[3*i +: 3]       = c.op;
    req_info1[32*i +: 32]     = c.i1;
    req_mem_info1[32*i +: 32] = c.m1;
    req_info2[32*i +: 32]     = c.i2;
    req_mem_info2[32*i +: 32] = c.m2;
  endtask

  // Called at a negedge; strobes last exactly one clock edge.
  task automatic release_strobes();
    @(negedge clk);
    req_start = '0;
  endtask

  task automatic strobe(input cmd_t c);
    drive(c);
    release_strobes();
  endtask

  task automatic wait_for_done(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (req_done == '0 && t < 200);
    if (req_done == '0) check({name, "_timeout"}, 160'(req_done), 160'(1));
  endtask

  task automatic wait_for_start(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!dma_start && t < 200);
    if (!dma_start) check({name, "_timeout"}, 160'(dma_start), 160'(1));
  endtask

  function automatic logic [159:0] all_outputs();
    return 160'({dma_start, dma_op, dma_info1, dma_mem_info1, dma_info2,
                 dma_mem_info2, req_done, req_err, busy, grant_id});
  endfunction

  // DMA model: f_dma arrives dma_lat cycles after the cycle holding dma_start.
  initial begin
    int cnt;
    cnt   = 0;
    f_dma = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      f_dma = force_fin;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) f_dma = 1'b1;
        end
        if (dma_start) cnt = dma_lat;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    cmd_t e, a;
    int   d;
    logic f_prev;
    f_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dma_start) begin
        if (exp_issue.size() == 0) begin
          check("start_unexpected", 160'(dma_start), 160'(0));
        end else begin
          e = exp_issue.pop_front();
          a = {grant_id, dma_op, dma_info1, dma_mem_info1, dma_info2, dma_mem_info2};
          check("issue", 160'(a), 160'(e));
        end
      end
      if (req_done != '0) begin
        check("done_after_fin", 160'(f_prev), 160'(1));
        if (exp_done.size() == 0) begin
          check("done_unexpected", 160'(req_done), 160'(0));
        end else begin
          d = exp_done.pop_front();
          check("done_id", 160'(req_done), 160'(3'b001 << d));
        end
      end
      if (req_err != '0) begin
        if (exp_err.size() == 0) begin
          check("err_unexpected", 160'(req_err), 160'(0));
        end else begin
          d = exp_err.pop_front();
          check("err_id", 160'(req_err), 160'(3'b001 << d));
        end
      end
      f_prev = f_dma;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    cmd_t c;
    logic seen;

    rst           = 1'b1;
    req_start     = '0;
    req_op        = '0;
    req_info1     = '0;
    req_mem_info1 = '0;
    req_info2     = '0;
    req_mem_info2 = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 160'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous strobes: served 0,1,2 straight out of reset.
    dma_lat = 4;
    for (int i = 0; i < NREQ; i++) begin
      c = mk(i, (i == 0) ? 1 : (i == 1) ? 2 : 5, i);
      exp_issue.push_back(c);
      exp_done.push_back(i);
      drive(c);
    end
    release_strobes();
    for (int i = 0; i < NREQ; i++) wait_for_done("simul");
    repeat (3) @(negedge clk);

    // Continuous load: each owner re-strobes in its done cycle.
    for (int n = 0; n < 9; n++) begin
      exp_issue.push_back(mk(n % 3, n % 8, 20 + n));
      exp_done.push_back(n % 3);
    end
    for (int i = 0; i < NREQ; i++) drive(mk(i, i, 20 + i));
    release_strobes();
    for (int n = 0; n < 9; n++) begin
      wait_for_done("cont");
      if (n < 6) strobe(mk(n % 3, (n + 3) % 8, 20 + n + 3));
    end
    repeat (3) @(negedge clk);

    // Single command from requester 1.
    dma_lat = 5;
    c = '{id: 2'd1, op: 3'd1, i1: 32'd9, m1: 32'h40, i2: 32'h11, m2: 32'h22};
    exp_issue.push_back(c);
    exp_done.push_back(1);
    strobe(c);
    check("single_start_early", 160'(dma_start), 160'(0));
    @(negedge clk);
    check("single_start_cycle2", 160'(dma_start), 160'(1));
    check("single_busy", 160'(busy), 160'(1));
    wait_for_done("single");
    @(negedge clk);
    check("single_busy_after", 160'(busy), 160'(0));
    repeat (2) @(negedge clk);

    // Duplicate strobes while requester 0 is in flight.
    dma_lat = 10;
    c = mk(0, 6, 40);
    exp_issue.push_back(c);
    exp_done.push_back(0);
    strobe(c);
    wait_for_start("dup");
    @(negedge clk);
    exp_err.push_back(0);
    strobe(mk(0, 3, 41));
    check("dup_err1", 160'(req_err), 160'(3'b001));
    @(negedge clk);
    exp_err.push_back(0);
    strobe(mk(0, 4, 42));
    check("dup_err2", 160'(req_err), 160'(3'b001));
    wait_for_done("dup");
    repeat (5) @(negedge clk);
    check("dup_idle", 160'({busy, dma_start}), 160'(0));

    // Spurious finish in IDLE.
    force_fin = 1'b1;
    @(negedge clk);
    force_fin = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_state", 160'({busy, dma_start, req_done}), 160'(0));
    dma_lat = 3;
    c = mk(2, 7, 50);
    exp_issue.push_back(c);
    exp_done.push_back(2);
    strobe(c);
    wait_for_done("spur_follow");
    repeat (2) @(negedge clk);

    // Reset mid-transfer with two commands still queued.
    dma_lat = 20;
    exp_issue.push_back(mk(0, 1, 60));
    for (int i = 0; i < NREQ; i++) drive(mk(i, i + 1, 60 + i));
    release_strobes();
    wait_for_start("rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", all_outputs(), 160'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | busy | dma_start | (|req_done);
    end
    check("rst_mid_quiet", 160'(seen), 160'(0));
    dma_lat = 3;
    c = mk(1, 2, 70);
    exp_issue.push_back(c);
    exp_done.push_back(1);
    strobe(c);
    wait_for_done("rst_follow");
    repeat (4) @(negedge clk);

    check("issue_queue_empty", 160'(exp_issue.size()), 160'(0));
    check("done_queue_empty", 160'(exp_done.size()), 160'(0));
    check("err_queue_empty", 160'(exp_err.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
